// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - state and side encodings shared by the 2:1 mux arbiter
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/mux_2_to_1.sv
// rtl/mux_2_to_1.sv - WIDTH-wide 2:1 select, sel=0 picks a, sel=1 picks b
module mux_2_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_2_to_1_arbiter.sv
// rtl/mux_2_to_1_arbiter.sv - round-robin REQ/GNT arbiter driving a shared 2:1 mux; MUX_ARB_TIMEOUT_EN adds a contention hold limit
module mux_2_to_1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             SEL,
    output logic             VALID,
    output logic [WIDTH-1:0] OUTPUT,
    output logic [WIDTH-1:0] OUTPUT_BAR
);

    if (MAX_HOLD < 2) begin : g_max_hold_check
        $error("MAX_HOLD must be at least 2");
    end

    arb_state_t       state, next_state;
    logic             last_winner;
    logic             sel_q;
    logic             valid_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] mux_y;
    logic             preempt;
    logic             grant_entry;

    mux_2_to_1 #(.WIDTH(WIDTH)) u_mux (
        .a  (A),
        .b  (B),
        .sel(sel_q),
        .y  (mux_y)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt;
    logic              other_req;

    assign other_req = (state == GRANT_A) ? REQ_B : REQ_A;
    assign preempt   = (state != IDLE) && other_req && (hold_cnt == HOLD_LAST);

    // Counts only contended cycles, so an uncontested owner keeps the grant forever.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_cnt <= '0;
        end else if (grant_entry) begin
            hold_cnt <= '0;
        end else if ((state != IDLE) && other_req && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (REQ_A && REQ_B) begin
                    next_state = (last_winner == SIDE_B) ? GRANT_A : GRANT_B;
                end else if (REQ_A) begin
                    next_state = GRANT_A;
                end else if (REQ_B) begin
                    next_state = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!REQ_A || preempt) begin
                    next_state = REQ_B ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (!REQ_B || preempt) begin
                    next_state = REQ_A ? GRANT_A : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign grant_entry = (next_state != state) && (next_state != IDLE);

    // SEL tracks the side being entered and is left untouched while idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            last_winner <= SIDE_B;
            sel_q       <= SIDE_A;
            valid_q     <= 1'b0;
            out_q       <= '0;
        end else begin
            state <= next_state;
            if (grant_entry) begin
                last_winner <= (next_state == GRANT_B) ? SIDE_B : SIDE_A;
                sel_q       <= (next_state == GRANT_B) ? SIDE_B : SIDE_A;
            end
            if (state != IDLE) begin
                out_q   <= mux_y;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign GNT_A      = (state == GRANT_A);
    assign GNT_B      = (state == GRANT_B);
    assign SEL        = sel_q;
    assign VALID      = valid_q;
    assign OUTPUT     = out_q;
    assign OUTPUT_BAR = ~out_q;

endmodule

// File: tb/tb_mux_2_to_1_arbiter.sv
// tb/tb_mux_2_to_1_arbiter.sv - scoreboard bench for mux_2_to_1_arbiter, expectations follow MUX_ARB_TIMEOUT_EN
module tb_mux_2_to_1_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ_A, REQ_B;
    logic [0:0] A, B;
    logic       GNT_A, GNT_B, SEL, VALID;
    logic [0:0] OUTPUT, OUTPUT_BAR;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [0:0] sb[$];
    logic       pend = 1'b0;

    mux_2_to_1_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .A         (A),
        .B         (B),
        .GNT_A     (GNT_A),
        .GNT_B     (GNT_B),
        .SEL       (SEL),
        .VALID     (VALID),
        .OUTPUT    (OUTPUT),
        .OUTPUT_BAR(OUTPUT_BAR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented VALID word must match the oldest expectation.
    always @(negedge CLK) begin
        logic [0:0] e;
        logic [0:0] eb;
        if (!RST && VALID) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", VALID, 1'b0);
            end else begin
                e  = sb.pop_front();
                eb = ~e;
                chk("output", OUTPUT[0], e[0]);
                chk("output_bar", OUTPUT_BAR[0], eb[0]);
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_gnt_a", GNT_A, 1'b0);
        chk("rst_gnt_b", GNT_B, 1'b0);
        chk("rst_sel", SEL, 1'b0);
        chk("rst_valid", VALID, 1'b0);
        chk("rst_output", OUTPUT[0], 1'b0);
        chk("rst_output_bar", OUTPUT_BAR[0], 1'b1);
    endtask

    // Checks the current grant, then pushes the word the next edge will capture.
    task automatic step(input logic ra, input logic rb, input logic a, input logic b,
                        input logic ega, input logic egb);
        REQ_A = ra;
        REQ_B = rb;
        A     = a;
        B     = b;
        chk("gnt_a", GNT_A, ega);
        chk("gnt_b", GNT_B, egb);
        chk("valid", VALID, pend);
        if (ega) begin
            chk("sel_a", SEL, 1'b0);
            sb.push_back(a);
        end
        if (egb) begin
            chk("sel_b", SEL, 1'b1);
            sb.push_back(b);
        end
        pend = ega | egb;
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous pulse: outputs must clear before any clock edge arrives.
    task automatic reset_pulse();
        #2 RST = 1'b1;
        #1;
        chk_reset_vals();
        sb.delete();
        pend = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        logic ega;
        RST   = 1'b1;
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        A     = 1'b0;
        B     = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Single requester A
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Mid-transaction reset while B owns the datapath with SEL=1
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 1);
        reset_pulse();

        // Simultaneous requests, then direct handover to B
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Four tie rounds alternate A,B,A,B
        for (int r = 0; r < 4; r++) begin
            logic wa;
            wa = (r % 2 == 0);
            step(1, 1, 1, 0, 0, 0);
            step(1, 1, 1, 0, wa, !wa);
            step(1, 1, 1, 0, wa, !wa);
            step(0, 0, 1, 0, wa, !wa);
            step(0, 0, 0, 0, 0, 0);
        end

        // Sustained contention for 20 grant cycles
        step(1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
`ifdef MUX_ARB_TIMEOUT_EN
            ega = ((k / 4) % 2 == 0);
`else
            ega = 1'b1;
`endif
            step(1, 1, 1, 0, ega, !ega);
        end
`ifdef MUX_ARB_TIMEOUT_EN
        ega = 1'b0;
`else
        ega = 1'b1;
`endif
        step(0, 0, 1, 0, ega, !ega);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset during GRANT_B with both requesting: A wins afterwards
        step(0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0, 1);
        reset_pulse();
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        @(negedge CLK);
        #1;
        chk("sb_drained", (sb.size() == 0), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
